// File: rtl/cpu_pkg.sv
// Encodings and types shared by the PC sequencer and the control unit.
// PCSel values 101-111 are not given names and decode as sequential fetch.
package cpu_pkg;

    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_BR   = 3'b001;
    localparam logic [2:0] PC_J    = 3'b010;
    localparam logic [2:0] PC_JR   = 3'b011;
    localparam logic [2:0] PC_HALT = 3'b100;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_unit_next_pc_mux.sv
// Combinational next-PC selection: sequential, branch, jump and register-indirect targets.
// All address arithmetic wraps modulo 2^32.
module next_pc_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [2:0]  pcsel_i,
    input  logic        bne_i,
    input  logic        zero_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] target26_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        taken_o,
    output logic        misaligned_o,
    output logic        is_halt_o
);

    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc_plus4_o   = pc_i + 32'd4;
    assign br_target    = pc_plus4_o + (sign_ext16(imm16_i) << 2);
    assign j_target     = {pc_plus4_o[31:28], target26_i, 2'b00};
    assign taken_o      = zero_i ^ bne_i;
    assign misaligned_o = (pcsel_i == PC_JR) && (rs_data_i[1:0] != 2'b00);
    assign is_halt_o    = (pcsel_i == PC_HALT);

    always_comb begin
        next_pc_o = pc_plus4_o;
        case (pcsel_i)
            PC_BR:   next_pc_o = taken_o ? br_target : pc_plus4_o;
            PC_J:    next_pc_o = j_target;
            PC_JR:   next_pc_o = rs_data_i;
            PC_HALT: next_pc_o = pc_i;
            default: next_pc_o = pc_plus4_o;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter, retired-instruction counter and RUN/HALTED sequencing.
// state | meaning: RUN = fetching and retiring; HALTED = frozen until reset.
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [2:0]       PCSel,
    input  logic             bne,
    input  logic             zero,
    input  logic             stall,
    input  logic [15:0]      imm16,
    input  logic [25:0]      target26,
    input  logic [31:0]      rsData,
    output logic [31:0]      pc,
    output logic [31:0]      retAddr,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault
);

    pc_state_e        state_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             halted_q;
    logic             fault_q;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        taken;
    logic        misaligned;
    logic        is_halt;

    next_pc_mux u_next_pc_mux (
        .pc_i         (pc_q),
        .pcsel_i      (PCSel),
        .bne_i        (bne),
        .zero_i       (zero),
        .imm16_i      (imm16),
        .target26_i   (target26),
        .rs_data_i    (rsData),
        .pc_plus4_o   (pc_plus4),
        .next_pc_o    (next_pc),
        .taken_o      (taken),
        .misaligned_o (misaligned),
        .is_halt_o    (is_halt)
    );

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    assign retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        if (misaligned) begin
                            fault_q  <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else if (is_halt) begin
                            retired_q <= retired_d;
                            halted_q  <= 1'b1;
                            state_q   <= HALTED;
                        end else begin
                            pc_q      <= next_pc;
                            retired_q <= retired_d;
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign pc      = pc_q;
    assign retAddr = pc_plus4;
    assign retired = retired_q;
    assign halted  = halted_q;
    assign fault   = fault_q;

    logic unused_taken;
    assign unused_taken = taken;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues the expected post-edge state,
// a monitor compares it one time unit after every rising edge.
module tb_pc_unit;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             reset;
    logic [2:0]       PCSel;
    logic             bne;
    logic             zero;
    logic             stall;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [31:0]      rsData;
    logic [31:0]      pc;
    logic [31:0]      retAddr;
    logic [CNT_W-1:0] retired;
    logic             halted;
    logic             fault;

    pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .PCSel    (PCSel),
        .bne      (bne),
        .zero     (zero),
        .stall    (stall),
        .imm16    (imm16),
        .target26 (target26),
        .rsData   (rsData),
        .pc       (pc),
        .retAddr  (retAddr),
        .retired  (retired),
        .halted   (halted),
        .fault    (fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string            name;
        logic [31:0]      pc;
        logic [CNT_W-1:0] ret;
        logic             h;
        logic             f;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step(input string name, input logic rst, input logic stl,
                        input logic [2:0] sel, input logic b, input logic z,
                        input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] rs, input logic [31:0] e_pc,
                        input logic [CNT_W-1:0] e_ret, input logic e_h, input logic e_f);
        exp_t e;
        @(negedge CLK);
        reset = rst; stall = stl; PCSel = sel; bne = b; zero = z;
        imm16 = imm; target26 = tgt; rsData = rs;
        e.name = name; e.pc = e_pc; e.ret = e_ret; e.h = e_h; e.f = e_f;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (pc !== e.pc || retired !== e.ret || halted !== e.h || fault !== e.f) begin
                    n_err++;
                    $display("FAIL %s: got pc=%h ret=%0d halted=%b fault=%b, want pc=%h ret=%0d halted=%b fault=%b",
                             e.name, pc, retired, halted, fault, e.pc, e.ret, e.h, e.f);
                end
                n_vec++;
                if (retAddr !== e.pc + 32'd4) begin
                    n_err++;
                    $display("FAIL %s_retaddr: got %h want %h", e.name, retAddr, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        logic [CNT_W-1:0] sat;
        reset = 1'b1; stall = 1'b0; PCSel = 3'b000; bne = 1'b0; zero = 1'b0;
        imm16 = '0; target26 = '0; rsData = '0;

        //     name         rst stl sel     b     z     imm       tgt       rs            pc             ret h  f
        step("reset",       1, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h0,         0,  0, 0);
        step("seq1",        0, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h4,         1,  0, 0);
        step("seq2",        0, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h8,         2,  0, 0);
        step("seq3",        0, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'hC,         3,  0, 0);
        step("jr_to_8",     0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'h8,        32'h8,         4,  0, 0);
        step("beq_taken",   0, 0, 3'b001, 0, 1, 16'h0003, 26'h0,    32'h0,        32'd24,        5,  0, 0);
        step("jr_to_8b",    0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'h8,        32'h8,         6,  0, 0);
        step("bne_not_tkn", 0, 0, 3'b001, 1, 1, 16'h0003, 26'h0,    32'h0,        32'd12,        7,  0, 0);
        step("jr_to_40",    0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'd40,       32'd40,        8,  0, 0);
        step("br_negative", 0, 0, 3'b001, 0, 1, 16'hFFFE, 26'h0,    32'h0,        32'd36,        9,  0, 0);
        step("bne_taken",   0, 0, 3'b001, 1, 0, 16'hFFFE, 26'h0,    32'h0,        32'd32,        10, 0, 0);
        step("jr_hi",       0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'h1000_0040, 32'h1000_0040, 11, 0, 0);
        step("jal",         0, 0, 3'b010, 0, 0, 16'h0,    26'h10,   32'h0,        32'h1000_0040, 12, 0, 0);
        step("sel_101",     0, 0, 3'b101, 0, 1, 16'h0040, 26'h0,    32'h0,        32'h1000_0044, 13, 0, 0);
        step("stall_seq",   0, 1, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h1000_0044, 13, 0, 0);
        step("stall_j",     0, 1, 3'b010, 0, 0, 16'h0,    26'h3,    32'h0,        32'h1000_0044, 13, 0, 0);
        step("stall_halt",  0, 1, 3'b100, 0, 0, 16'h0,    26'h0,    32'h0,        32'h1000_0044, 13, 0, 0);
        step("jr_80",       0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'h80,       32'h80,        14, 0, 0);
        step("jr_misalign", 0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'h13,       32'h80,        14, 1, 1);
        step("halted_seq",  0, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h80,        14, 1, 1);
        step("halted_jr",   0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'h40,       32'h80,        14, 1, 1);
        step("reset2",      1, 1, 3'b100, 0, 0, 16'h0,    26'h0,    32'h0,        32'h0,         0,  0, 0);
        step("jr_top",      0, 0, 3'b011, 0, 0, 16'h0,    26'h0,    32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,  0, 0);
        step("wrap",        0, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h0,         2,  0, 0);
        step("halt",        0, 0, 3'b100, 0, 0, 16'h0,    26'h0,    32'h0,        32'h0,         3,  1, 0);
        step("halted_hold", 0, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h0,         3,  1, 0);
        step("reset3",      1, 0, 3'b000, 0, 0, 16'h0,    26'h0,    32'h0,        32'h0,         0,  0, 0);
        for (int n = 1; n <= 17; n++) begin
            sat = (n > 15) ? 4'd15 : 4'(n);
            step("sat_seq", 0, 0, 3'b000, 0, 0, 16'h0, 26'h0, 32'h0, 32'(4 * n), sat, 0, 0);
        end
        step("sat_halt",    0, 0, 3'b100, 0, 0, 16'h0,    26'h0,    32'h0,        32'd68,        15, 1, 0);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge CLK);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
